// File: rtl/bsn_sort_scheduler.sv
// First-word fall-through FIFO; 0-cycle read latency, push visible on out_vld the cycle after.
// No internal backpressure: the writer must never push when full (simultaneous push+pop when full is fine).
module bsn_sort_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic [WIDTH-1:0]       in_dat,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [WIDTH-1:0]       out_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign out_vld = (count != '0);
    assign pop     = out_vld & out_rdy;
    assign out_dat = out_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (in_vld) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (in_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({in_vld, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Round-robin issue of two requesters into the fixed-latency BSN, results returned through a FWFT FIFO.
// Accept-to-out_valid is SORT_LATENCY+1 cycles; requesters stall on FIFO credit so the BSN never does.
module bsn_sort_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int N_INPUTS     = 8,
    parameter int SORT_LATENCY = 6,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [DATA_WIDTH*N_INPUTS-1:0] req0_data,
    input  logic                         req0_dir,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [DATA_WIDTH*N_INPUTS-1:0] req1_data,
    input  logic                         req1_dir,
    output logic                         bsn_en,
    output logic [DATA_WIDTH*N_INPUTS-1:0] bsn_data_in,
    output logic                         bsn_direction,
    input  logic [DATA_WIDTH*N_INPUTS-1:0] bsn_data_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*N_INPUTS-1:0] out_data,
    output logic                         out_src,
    output logic                         busy
);
    localparam int VW = DATA_WIDTH * N_INPUTS;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

    logic                    grant0;
    logic                    grant1;
    logic                    accept;
    logic                    credit_ok;
    logic                    last_grant;
    logic                    issue_vld;
    logic                    issue_src;
    logic [SORT_LATENCY-1:0] tag_vld;
    logic [SORT_LATENCY-1:0] tag_src;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic                    cap_vld;
    logic [VW:0]             fifo_dat;

    // Counting in-flight work against free slots means a capture can always be pushed.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDIT_LIMIT;
    assign grant0    = !rst && credit_ok && req0_valid && (!req1_valid || last_grant);
    assign grant1    = !rst && credit_ok && req1_valid && (!req0_valid || !last_grant);
    assign accept    = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign bsn_en  = issue_vld | (|tag_vld);
    assign cap_vld = bsn_en & tag_vld[SORT_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_vld     <= 1'b0;
            issue_src     <= 1'b0;
            bsn_data_in   <= '0;
            bsn_direction <= 1'b0;
            last_grant    <= 1'b1;
            inflight      <= '0;
        end else begin
            issue_vld <= accept;
            if (accept) begin
                issue_src     <= grant1;
                last_grant    <= grant1;
                bsn_data_in   <= grant1 ? req1_data : req0_data;
                bsn_direction <= grant1 ? req1_dir  : req0_dir;
            end
            case ({accept, cap_vld})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Tags move in lockstep with the BSN so the last stage marks when bsn_data_out is real.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            tag_src <= '0;
        end else if (bsn_en) begin
            tag_vld[0] <= issue_vld;
            tag_src[0] <= issue_src;
            for (int i = 1; i < SORT_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_src[i] <= tag_src[i-1];
            end
        end
    end

    bsn_sort_fifo #(
        .WIDTH (VW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (cap_vld),
        .in_dat  ({tag_src[SORT_LATENCY-1], bsn_data_out}),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (fifo_dat),
        .count   (fifo_count)
    );

    assign out_src  = fifo_dat[VW];
    assign out_data = fifo_dat[VW-1:0];
    assign busy     = issue_vld | (inflight != '0) | out_valid;
endmodule

// File: tb/tb_bsn_sort_scheduler.sv
// Directed and random checks of bsn_sort_scheduler against a behavioural BSN and a scoreboard.
module tb_bsn_sort_scheduler;
    localparam int DW    = 32;
    localparam int N     = 8;
    localparam int LAT   = 6;
    localparam int DEPTH = 4;
    localparam int VW    = DW * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_dir;
    logic          req1_valid, req1_ready, req1_dir;
    logic [VW-1:0] req0_data, req1_data;
    logic          bsn_en, bsn_direction;
    logic [VW-1:0] bsn_data_in, bsn_data_out;
    logic          out_valid, out_ready, out_src, busy;
    logic [VW-1:0] out_data;

    int tests = 0;
    int fails = 0;
    int n_acc = 0;
    int n_pop = 0;

    typedef struct packed {
        logic [VW-1:0] dat;
        logic          src;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bsn_sort_scheduler #(
        .DATA_WIDTH   (DW),
        .N_INPUTS     (N),
        .SORT_LATENCY (LAT),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_data     (req0_data),
        .req0_dir      (req0_dir),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_data     (req1_data),
        .req1_dir      (req1_dir),
        .bsn_en        (bsn_en),
        .bsn_data_in   (bsn_data_in),
        .bsn_direction (bsn_direction),
        .bsn_data_out  (bsn_data_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_src       (out_src),
        .busy          (busy)
    );

    function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v, input logic desc);
        logic [DW-1:0] e [N];
        logic [DW-1:0] t;
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) e[i] = v[i*DW +: DW];
        for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (desc ? (e[j] < e[j+1]) : (e[j] > e[j+1])) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
        for (int i = 0; i < N; i++) r[i*DW +: DW] = e[i];
        return r;
    endfunction

    function automatic logic [VW-1:0] vec8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Behavioural BSN: SORT_LATENCY enabled cycles from bsn_data_in to bsn_data_out.
    logic [VW-1:0] bsn_pipe [LAT];
    always @(posedge clk) begin
        if (bsn_en) begin
            bsn_pipe[0] <= sort_vec(bsn_data_in, bsn_direction);
            for (int i = 1; i < LAT; i++) bsn_pipe[i] <= bsn_pipe[i-1];
        end
    end
    assign bsn_data_out = bsn_pipe[LAT-1];

    task automatic check(input string tag, input logic [VW:0] got, input logic [VW:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: accepts enqueue the expected sorted result, pops must match in issue order.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_pop_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_out_data", out_data, e.dat);
                    check("sb_out_src", out_src, e.src);
                end
                n_pop++;
            end
            if (req0_valid && req0_ready) begin
                sb.push_back('{dat: sort_vec(req0_data, req0_dir), src: 1'b0});
                n_acc++;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back('{dat: sort_vec(req1_data, req1_dir), src: 1'b1});
                n_acc++;
            end
        end
    end

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        @(negedge clk);
        check(tag, busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic send0(input int n, input int base);
        int got = 0;
        int c = 0;
        req0_valid = 1'b1;
        req0_dir   = 1'b0;
        while (got < n && c < 100) begin
            req0_data = vec8(base + got, 3, 90, base, 1, 44, 2, 7);
            @(negedge clk);
            if (req0_ready) got++;
            @(posedge clk); #1;
            c++;
        end
        req0_valid = 1'b0;
        check("send0_accepts", got, n);
    endtask

    initial begin
        int lat, acc, exp_id, n, c, acc_start, pop_start;

        rst = 1'b1;
        req0_valid = 1'b1; req0_dir = 1'b0; req0_data = vec8(1, 2, 3, 4, 5, 6, 7, 8);
        req1_valid = 1'b0; req1_dir = 1'b0; req1_data = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_bsn_en", bsn_en, 0);
        check("rst_busy", busy, 0);
        check("rst_bsn_data_in", bsn_data_in, 0);
        check("rst_bsn_direction", bsn_direction, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0;

        // Contention: grants alternate starting with requester 0.
        req0_valid = 1'b1; req0_dir = 1'b0; req0_data = vec8(8, 3, 6, 1, 7, 2, 5, 4);
        req1_valid = 1'b1; req1_dir = 1'b1; req1_data = vec8(12, 40, 25, 7, 33, 18, 2, 50);
        out_ready  = 1'b1;
        exp_id = 0; n = 0; c = 0;
        while (n < 8 && c < 200) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                check("t2_grant", {req0_ready, req1_ready}, (exp_id == 0) ? 2'b10 : 2'b01);
                exp_id = 1 - exp_id;
                n++;
            end
            @(posedge clk); #1;
            c++;
        end
        check("t2_grant_count", n, 8);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("t2_drain");

        // Single vector latency and content.
        req0_valid = 1'b1; req0_dir = 1'b0; req0_data = vec8(5, 7, 4, 1, 0, 6, 3, 2);
        @(negedge clk);
        check("t1_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        check("t1_latency", lat, LAT + 1);
        check("t1_out_data", out_data, vec8(0, 1, 2, 3, 4, 5, 6, 7));
        check("t1_out_src", out_src, 0);

        // Idle gating: BSN frozen, inputs held, re-enabled the cycle after an accept.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_bsn_en_idle", bsn_en, 0);
        check("t4_busy_idle", busy, 0);
        check("t4_bsn_data_hold", bsn_data_in, vec8(5, 7, 4, 1, 0, 6, 3, 2));
        check("t4_bsn_dir_hold", bsn_direction, 0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_dir = 1'b1; req0_data = vec8(9, 2, 11, 4, 0, 6, 13, 1);
        @(negedge clk);
        check("t4_bsn_en_before", bsn_en, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("t4_bsn_en_after", bsn_en, 1);
        check("t4_bsn_dir_new", bsn_direction, 1);
        wait_idle("t4_drain");

        // Back-pressure: credits cap accepts at FIFO_DEPTH.
        out_ready = 1'b0;
        acc = 0;
        req0_valid = 1'b1; req0_dir = 1'b0;
        for (int k = 0; k < 10; k++) begin
            req0_data = vec8(acc + 1, 20, 3 * acc, 7, 100 - acc, 0, acc, 9);
            @(negedge clk);
            if (req0_ready) acc++;
            @(posedge clk); #1;
        end
        check("t3_accepts", acc, DEPTH);
        @(negedge clk);
        check("t3_ready_low", req0_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            req0_data = vec8(50 + acc, 20, 3, 7, 1, 0, 8, 9);
            @(negedge clk);
            if (req0_ready) acc++;
            @(posedge clk); #1;
        end
        check("t3_one_more", acc, 1);
        req0_valid = 1'b0;
        out_ready  = 1'b1;
        wait_idle("t3_drain");
        check("t3_sb_empty", sb.size(), 0);

        // Reset with work both buffered and in flight; last grant before reset was requester 0.
        out_ready = 1'b0;
        send0(2, 50);
        repeat (LAT + 4) @(posedge clk);
        #1;
        send0(2, 60);
        repeat (2) @(posedge clk);
        #1;
        check("t5_busy_pre", busy, 1);
        rst = 1'b1;
        req0_valid = 1'b1; req0_dir = 1'b0; req0_data = vec8(4, 3, 2, 1, 8, 7, 6, 5);
        req1_valid = 1'b1; req1_dir = 1'b1; req1_data = vec8(1, 2, 3, 4, 5, 6, 7, 8);
        @(negedge clk);
        check("t5_rst_ready0", req0_ready, 0);
        check("t5_rst_ready1", req1_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_bsn_en", bsn_en, 0);
        check("t5_first_grant", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle("t5_drain");

        // Random traffic against the scoreboard.
        acc_start = n_acc;
        pop_start = n_pop;
        c = 0;
        while ((n_acc - acc_start) < 1000 && c < 30000) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_dir   = 1'($urandom_range(0, 1));
            req1_dir   = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                req0_data[i*DW +: DW] = $urandom_range(0, 255);
                req1_data[i*DW +: DW] = $urandom_range(0, 255);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            c++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        out_ready  = 1'b1;
        wait_idle("t6_drain");
        check("t6_accepts", n_acc - acc_start, 1000);
        check("t6_pops", n_pop - pop_start, 1000);
        check("t6_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
